// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: pops a fixed-length burst from a show-ahead FIFO onto a valid/ready stream.
// Optional checksum tail beat enabled by defining FIFO_BURST_READER_CHECKSUM_EN.
module fifo_burst_reader #(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] fifo_data,
  input  logic              fifo_empty,
  output logic              fifo_rn,
  input  logic              start,
  input  logic [LEN_W-1:0]  burst_len,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last
);
  typedef enum logic [1:0] {IDLE, XFER, TAIL} state_t;
  state_t            state_q, state_d;
  logic [LEN_W:0]    rem_q, rem_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d, last_q, last_d, done_q, done_d;
  logic              free, hs;
`ifdef FIFO_BURST_READER_CHECKSUM_EN
  logic [7:0]        sum_q, sum_d;
`endif
  assign free    = !valid_q || m_ready;
  assign hs      = valid_q && m_ready;
  assign fifo_rn = (state_q == XFER) && (rem_q != '0) && !fifo_empty && free;
  assign busy    = state_q != IDLE;
  assign done    = done_q;
  assign m_data  = data_q;
  assign m_valid = valid_q;
  assign m_last  = last_q;
  // Next state, burst counter and output register loading
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    data_d  = data_q;
    valid_d = valid_q && !m_ready;
    last_d  = hs ? 1'b0 : last_q;
    done_d  = 1'b0;
`ifdef FIFO_BURST_READER_CHECKSUM_EN
    sum_d   = sum_q;
`endif
    case (state_q)
      IDLE: if (start) begin
        state_d = XFER;
        rem_d   = (burst_len == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, burst_len};
`ifdef FIFO_BURST_READER_CHECKSUM_EN
        sum_d   = '0;
`endif
      end
      XFER: if (fifo_rn && rem_q == (LEN_W+1)'(1)) state_d = TAIL;
      TAIL: begin
`ifdef FIFO_BURST_READER_CHECKSUM_EN
        if (!last_q && free) begin
          data_d  = DATA_W'(sum_q);
          valid_d = 1'b1;
          last_d  = 1'b1;
        end else if (last_q && hs) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
`else
        if (hs) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
    if (fifo_rn) begin
      data_d  = fifo_data;
      valid_d = 1'b1;
      rem_d   = rem_q - (LEN_W+1)'(1);
`ifdef FIFO_BURST_READER_CHECKSUM_EN
      last_d  = 1'b0;
      sum_d   = sum_q + 8'(fifo_data);
`else
      last_d  = rem_q == (LEN_W+1)'(1);
`endif
    end
  end
  // State and output registers, cleared immediately on reset
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end
`ifdef FIFO_BURST_READER_CHECKSUM_EN
  // Running modulo-256 sum of the words popped in the current burst
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) sum_q <= '0;
    else          sum_q <= sum_d;
  end
`endif
endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb_fifo_burst_reader: directed checks of the burst reader against a FIFO model.
module tb_fifo_burst_reader;
  logic       clock = 1'b0, reset_n = 1'b0;
  logic [7:0] fifo_data;
  logic       fifo_empty, fifo_rn;
  logic       start = 1'b0;
  logic [3:0] burst_len = '0;
  logic       busy, done;
  logic [7:0] m_data;
  logic       m_valid, m_last;
  logic       m_ready = 1'b1;

  fifo_burst_reader #(.DATA_W(8), .LEN_W(4)) dut (
    .clock(clock), .reset_n(reset_n), .fifo_data(fifo_data), .fifo_empty(fifo_empty),
    .fifo_rn(fifo_rn), .start(start), .burst_len(burst_len), .busy(busy), .done(done),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last)
  );

  always #5 clock = ~clock;

  logic [7:0] mem [0:31];
  int wr = 0, rd = 0;
  assign fifo_data  = mem[rd[4:0]];
  assign fifo_empty = (rd == wr);

  int pops = 0, dones = 0, nb = 0, cyc = 0, viol = 0;
  logic [7:0] bd [0:127];
  logic       bl [0:127];
  int         bc [0:127];
  int nchk = 0, nfail = 0;
  logic [7:0] exp_d [$];
  logic       exp_l [$];

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (fifo_rn) begin
      rd   <= rd + 1;
      pops <= pops + 1;
    end
    if (done) dones <= dones + 1;
    if (m_valid && m_ready) begin
      bd[nb] <= m_data;
      bl[nb] <= m_last;
      bc[nb] <= cyc;
      nb     <= nb + 1;
    end
  end

  always @(negedge clock)
    if ((fifo_rn && (fifo_empty || !busy)) || (done && busy)) viol <= viol + 1;

  task automatic push(input logic [7:0] v);
    mem[wr[4:0]] = v;
    wr++;
  endtask

  task automatic expect_burst(input logic [7:0] w [$]);
    logic [7:0] s = '0;
    foreach (w[i]) begin
      s += w[i];
      exp_d.push_back(w[i]);
`ifdef FIFO_BURST_READER_CHECKSUM_EN
      exp_l.push_back(1'b0);
`else
      exp_l.push_back(i == w.size() - 1);
`endif
    end
`ifdef FIFO_BURST_READER_CHECKSUM_EN
    exp_d.push_back(s);
    exp_l.push_back(1'b1);
`endif
  endtask

  task automatic go(input logic [3:0] len);
    @(negedge clock);
    start = 1'b1;
    burst_len = len;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_dones(input int target, output bit ok);
    int t = 0;
    while (dones < target && t < 100) begin
      @(negedge clock);
      t++;
    end
    ok = dones >= target;
  endtask

  task automatic test_reset;
    #1;
    nchk++;
    if ({m_valid, m_last, m_data, done, busy, fifo_rn} !== 13'd0) begin
      nfail++;
      $display("FAIL reset outputs: got v=%b l=%b d=%h done=%b busy=%b rn=%b required all 0",
               m_valid, m_last, m_data, done, busy, fifo_rn);
    end
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    nchk++;
    if ({busy, fifo_rn} !== 2'b00) begin
      nfail++;
      $display("FAIL reset idle: got busy=%b rn=%b required 0 0", busy, fifo_rn);
    end
  endtask

  task automatic test_basic;
    int b0, p0, d0;
    bit ok;
    exp_d.delete(); exp_l.delete();
    expect_burst('{8'h11, 8'h22, 8'h33});
    push(8'h11); push(8'h22); push(8'h33);
    b0 = nb; p0 = pops; d0 = dones;
    @(negedge clock);
    start = 1'b1; burst_len = 4'd3;
    @(negedge clock);
    nchk++;
    if ({fifo_rn, busy, m_valid} !== 3'b110) begin
      nfail++;
      $display("FAIL basic latency1: got rn=%b busy=%b v=%b required 1 1 0", fifo_rn, busy, m_valid);
    end
    start = 1'b0;
    @(negedge clock);
    nchk++;
    if ({m_valid, m_data} !== {1'b1, 8'h11}) begin
      nfail++;
      $display("FAIL basic latency2: got v=%b d=%h required 1 11", m_valid, m_data);
    end
    wait_dones(d0 + 1, ok);
    nchk++;
    if (!ok) begin nfail++; $display("FAIL basic timeout: got no done required done"); end
    repeat (2) @(negedge clock);
    nchk++;
    if (dones - d0 !== 1) begin nfail++; $display("FAIL basic dones: got %0d required 1", dones - d0); end
    nchk++;
    if (pops - p0 !== 3) begin nfail++; $display("FAIL basic pops: got %0d required 3", pops - p0); end
    nchk++;
    if (nb - b0 !== exp_d.size()) begin
      nfail++; $display("FAIL basic beat count: got %0d required %0d", nb - b0, exp_d.size());
    end
    for (int i = 0; i < exp_d.size(); i++) begin
      nchk++;
      if ({bl[b0+i], bd[b0+i]} !== {exp_l[i], exp_d[i]}) begin
        nfail++;
        $display("FAIL basic beat%0d: got %h last=%b required %h last=%b", i, bd[b0+i], bl[b0+i], exp_d[i], exp_l[i]);
      end
    end
    for (int i = 1; i < exp_d.size(); i++) begin
      nchk++;
      if (bc[b0+i] - bc[b0+i-1] !== 1) begin
        nfail++; $display("FAIL basic spacing%0d: got %0d cycles required 1", i, bc[b0+i] - bc[b0+i-1]);
      end
    end
  endtask

  task automatic test_empty_stall;
    int b0, p0, d0;
    bit ok;
    exp_d.delete(); exp_l.delete();
    expect_burst('{8'hA0, 8'hA1});
    b0 = nb; p0 = pops; d0 = dones;
    go(4'd2);
    for (int i = 0; i < 5; i++) begin
      nchk++;
      if ({fifo_rn, busy} !== 2'b01) begin
        nfail++; $display("FAIL stall cycle%0d: got rn=%b busy=%b required 0 1", i, fifo_rn, busy);
      end
      @(negedge clock);
    end
    push(8'hA0); push(8'hA1);
    wait_dones(d0 + 1, ok);
    nchk++;
    if (!ok) begin nfail++; $display("FAIL stall timeout: got no done required done"); end
    @(negedge clock);
    nchk++;
    if (pops - p0 !== 2) begin nfail++; $display("FAIL stall pops: got %0d required 2", pops - p0); end
    nchk++;
    if (nb - b0 !== exp_d.size()) begin
      nfail++; $display("FAIL stall beat count: got %0d required %0d", nb - b0, exp_d.size());
    end
    for (int i = 0; i < exp_d.size(); i++) begin
      nchk++;
      if ({bl[b0+i], bd[b0+i]} !== {exp_l[i], exp_d[i]}) begin
        nfail++;
        $display("FAIL stall beat%0d: got %h last=%b required %h last=%b", i, bd[b0+i], bl[b0+i], exp_d[i], exp_l[i]);
      end
    end
  endtask

  task automatic test_backpressure;
    int b0, p0, d0, t;
    bit ok;
    exp_d.delete(); exp_l.delete();
    expect_burst('{8'h11, 8'h22, 8'h33});
    push(8'h11); push(8'h22); push(8'h33);
    b0 = nb; p0 = pops; d0 = dones;
    m_ready = 1'b0;
    go(4'd3);
    t = 0;
    while (!m_valid && t < 10) begin @(negedge clock); t++; end
    for (int i = 0; i < 4; i++) begin
      nchk++;
      if ({m_valid, m_last, m_data} !== {2'b10, 8'h11}) begin
        nfail++; $display("FAIL bp hold%0d: got v=%b l=%b d=%h required 1 0 11", i, m_valid, m_last, m_data);
      end
      @(negedge clock);
    end
    nchk++;
    if (pops - p0 !== 1) begin nfail++; $display("FAIL bp pops held: got %0d required 1", pops - p0); end
    m_ready = 1'b1;
    wait_dones(d0 + 1, ok);
    nchk++;
    if (!ok) begin nfail++; $display("FAIL bp timeout: got no done required done"); end
    @(negedge clock);
    nchk++;
    if (pops - p0 !== 3) begin nfail++; $display("FAIL bp pops: got %0d required 3", pops - p0); end
    nchk++;
    if (nb - b0 !== exp_d.size()) begin
      nfail++; $display("FAIL bp beat count: got %0d required %0d", nb - b0, exp_d.size());
    end
    for (int i = 0; i < exp_d.size(); i++) begin
      nchk++;
      if ({bl[b0+i], bd[b0+i]} !== {exp_l[i], exp_d[i]}) begin
        nfail++;
        $display("FAIL bp beat%0d: got %h last=%b required %h last=%b", i, bd[b0+i], bl[b0+i], exp_d[i], exp_l[i]);
      end
    end
  endtask

  task automatic test_reset_mid;
    int b0, p0, p1, d0, t;
    bit ok;
    for (int i = 0; i < 8; i++) push(8'h80 + 8'(i));
    b0 = nb; p0 = pops;
    go(4'd8);
    t = 0;
    while (nb - b0 < 2 && t < 20) begin @(negedge clock); t++; end
    reset_n = 1'b0;
    #1;
    nchk++;
    if ({m_valid, m_last, m_data, done, busy, fifo_rn} !== 13'd0) begin
      nfail++;
      $display("FAIL midreset outputs: got v=%b l=%b d=%h done=%b busy=%b rn=%b required all 0",
               m_valid, m_last, m_data, done, busy, fifo_rn);
    end
    p1 = pops;
    nchk++;
    if (p1 - p0 !== 3) begin nfail++; $display("FAIL midreset popped: got %0d required 3", p1 - p0); end
    repeat (3) @(negedge clock);
    nchk++;
    if (pops !== p1) begin nfail++; $display("FAIL midreset no pops: got %0d required %0d", pops, p1); end
    reset_n = 1'b1;
    exp_d.delete(); exp_l.delete();
    expect_burst('{8'h83});
    b0 = nb; p0 = pops; d0 = dones;
    go(4'd1);
    wait_dones(d0 + 1, ok);
    nchk++;
    if (!ok) begin nfail++; $display("FAIL midreset timeout: got no done required done"); end
    repeat (2) @(negedge clock);
    nchk++;
    if (pops - p0 !== 1) begin nfail++; $display("FAIL midreset len1 pops: got %0d required 1", pops - p0); end
    nchk++;
    if (nb - b0 !== exp_d.size()) begin
      nfail++; $display("FAIL midreset beat count: got %0d required %0d", nb - b0, exp_d.size());
    end
    for (int i = 0; i < exp_d.size(); i++) begin
      nchk++;
      if ({bl[b0+i], bd[b0+i]} !== {exp_l[i], exp_d[i]}) begin
        nfail++;
        $display("FAIL midreset beat%0d: got %h last=%b required %h last=%b", i, bd[b0+i], bl[b0+i], exp_d[i], exp_l[i]);
      end
    end
    wr = rd;
  endtask

  task automatic test_full_len;
    int b0, p0, d0;
    bit ok;
    logic [7:0] w [$];
    exp_d.delete(); exp_l.delete();
    for (int i = 0; i < 16; i++) begin
      w.push_back(8'h40 + 8'(i));
      push(8'h40 + 8'(i));
    end
    expect_burst(w);
    b0 = nb; p0 = pops; d0 = dones;
    go(4'd0);
    repeat (4) @(negedge clock);
    start = 1'b1; burst_len = 4'd3;
    @(negedge clock);
    start = 1'b0;
    wait_dones(d0 + 1, ok);
    nchk++;
    if (!ok) begin nfail++; $display("FAIL full timeout: got no done required done"); end
    repeat (3) @(negedge clock);
    nchk++;
    if ({busy, dones - d0} !== {1'b0, 32'd1}) begin
      nfail++; $display("FAIL full idle: got busy=%b dones=%0d required 0 1", busy, dones - d0);
    end
    nchk++;
    if (pops - p0 !== 16) begin nfail++; $display("FAIL full pops: got %0d required 16", pops - p0); end
    nchk++;
    if (nb - b0 !== exp_d.size()) begin
      nfail++; $display("FAIL full beat count: got %0d required %0d", nb - b0, exp_d.size());
    end
    for (int i = 0; i < exp_d.size(); i++) begin
      nchk++;
      if ({bl[b0+i], bd[b0+i]} !== {exp_l[i], exp_d[i]}) begin
        nfail++;
        $display("FAIL full beat%0d: got %h last=%b required %h last=%b", i, bd[b0+i], bl[b0+i], exp_d[i], exp_l[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    int b0, p0, d0, t;
    bit ok;
    exp_d.delete(); exp_l.delete();
    expect_burst('{8'h01, 8'h02, 8'h03});
    expect_burst('{8'h04, 8'h05, 8'h06});
    for (int i = 1; i <= 6; i++) push(8'(i));
    b0 = nb; p0 = pops; d0 = dones;
    go(4'd3);
    t = 0;
    while (!done && t < 30) begin @(negedge clock); t++; end
    nchk++;
    if ({done, busy} !== 2'b10) begin
      nfail++; $display("FAIL b2b done cycle: got done=%b busy=%b required 1 0", done, busy);
    end
    start = 1'b1; burst_len = 4'd3;
    @(negedge clock);
    start = 1'b0;
    nchk++;
    if (busy !== 1'b1) begin nfail++; $display("FAIL b2b restart: got busy=%b required 1", busy); end
    wait_dones(d0 + 2, ok);
    nchk++;
    if (!ok) begin nfail++; $display("FAIL b2b timeout: got %0d dones required 2", dones - d0); end
    @(negedge clock);
    nchk++;
    if (pops - p0 !== 6) begin nfail++; $display("FAIL b2b pops: got %0d required 6", pops - p0); end
    nchk++;
    if (nb - b0 !== exp_d.size()) begin
      nfail++; $display("FAIL b2b beat count: got %0d required %0d", nb - b0, exp_d.size());
    end
    for (int i = 0; i < exp_d.size(); i++) begin
      nchk++;
      if ({bl[b0+i], bd[b0+i]} !== {exp_l[i], exp_d[i]}) begin
        nfail++;
        $display("FAIL b2b beat%0d: got %h last=%b required %h last=%b", i, bd[b0+i], bl[b0+i], exp_d[i], exp_l[i]);
      end
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_empty_stall;
    test_backpressure;
    test_reset_mid;
    test_full_len;
    test_back_to_back;
    nchk++;
    if (viol !== 0) begin
      nfail++; $display("FAIL protocol: got %0d cycles with pop while empty/idle or done while busy required 0", viol);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule

// File: doc/fifo_burst_reader.md
FIFO_BURST_READER -- requirements
Module: fifo_burst_reader

Interface
REQ-001 Parameter DATA_W, default 8, width of FIFO read data and stream data.
REQ-002 Parameter LEN_W, default 4, width of burst_len.
REQ-003 clock  input  1  sole clock; all state updates on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 fifo_data  input  DATA_W  FIFO head word; show-ahead, valid whenever fifo_empty is low.
REQ-006 fifo_empty  input  1  FIFO empty flag.
REQ-007 fifo_rn  output  1  FIFO pop strobe; FIFO advances on the rising edge where it is high.
REQ-008 start  input  1  burst request; sampled only in IDLE.
REQ-009 burst_len  input  LEN_W  data words per burst; 0 means 2^LEN_W.
REQ-010 busy  output  1  high in any state other than IDLE.
REQ-011 done  output  1  one-cycle pulse after the final beat of a burst is accepted.
REQ-012 m_data  output  DATA_W  stream data, registered.
REQ-013 m_valid  output  1  stream valid.
REQ-014 m_ready  input  1  stream ready from downstream.
REQ-015 m_last  output  1  marks the final beat of a burst; qualified by m_valid.

Function
REQ-016 FSM states SHALL be IDLE, XFER, TAIL; transitions IDLE->XFER on start, XFER->TAIL once the last data word is popped, TAIL->IDLE on the final handshake.
REQ-017 In IDLE with start high, burst_len SHALL be latched into a remaining-count register (0 -> 2^LEN_W); later burst_len changes are ignored.
REQ-018 start SHALL be ignored while busy is high.
REQ-019 fifo_rn SHALL be combinational: high only in XFER, when remaining > 0, fifo_empty low, and the output register is free (m_valid low or m_ready high).
REQ-020 On each edge with fifo_rn high, m_data <= fifo_data, m_valid <= 1, and remaining decrements by 1.
REQ-021 A beat transfers on an edge where m_valid and m_ready are both high; m_valid clears on that edge unless a new word loads in the same edge.
REQ-022 m_data, m_last and m_valid SHALL hold stable while m_valid is high and m_ready is low.
REQ-023 Throughput SHALL be one word per cycle with fifo_empty low and m_ready held high.
REQ-024 Latency: start sampled at edge E0 -> fifo_rn may assert in the cycle after E0 -> m_valid high after the next edge E1.
REQ-025 fifo_empty high mid-burst SHALL stall popping without error; the held word remains presented until accepted.
REQ-026 fifo_rn SHALL never be high while fifo_empty is high or outside XFER.
REQ-027 The final handshake of a burst SHALL return the FSM to IDLE and assert done for exactly the following cycle, with busy low in that cycle.
REQ-028 start high in the done cycle SHALL be accepted as a new burst.

Reset
REQ-029 reset_n low SHALL immediately force: state IDLE, remaining 0, m_valid 0, m_last 0, m_data 0, done 0, busy 0, fifo_rn 0, checksum accumulator 0.
REQ-030 Reset mid-burst SHALL abort the burst with no further pops; words already popped are discarded.

Configuration
REQ-031 Macro FIFO_BURST_READER_CHECKSUM_EN SHALL control the checksum tail beat.
REQ-032 Defined: the reader keeps an 8-bit modulo-256 sum of the burst's popped data words; in TAIL, once the output register is free, it loads that sum as one extra beat with m_last high, and no FIFO pop occurs for it.
REQ-033 Undefined: m_last SHALL be set with the last data word, TAIL SHALL only wait for that beat's handshake, and no sum logic is synthesised.

Verification
REQ-034 FIFO holds 0x11,0x22,0x33; burst_len=3; m_ready=1 -> beats 0x11,0x22,0x33 on consecutive cycles, m_last on 0x33, done pulses once, and 3 fifo_rn pulses occur in total.
REQ-035 Same stimulus with CHECKSUM_EN defined -> fourth beat 0x66 with m_last high, and only 3 pops.
REQ-036 burst_len=2 with the FIFO empty for 5 cycles after start, then 0xA0,0xA1 written -> no fifo_rn while empty, then 2 beats and done.
REQ-037 m_ready low for 4 cycles with the first beat 0x11 valid -> m_data stays 0x11, m_valid stays high, no extra pops, and the burst then completes.
REQ-038 reset_n low two beats into an 8-word burst -> all outputs at reset values at once; after release, start with burst_len=1 pops exactly one word.
REQ-039 burst_len=0 with 16 words queued -> 16 beats, m_last on the 16th; start pulsed mid-burst is ignored.
